keypad_scan4x4: RTL and testbench

Active scanner for the 4x4 membrane keypad. It drives the keypad row lines one at a time and samples the column lines. Each sample frame is debounced and rejected if it shows ghosting. For each debounced key press it emits one active-low row/column code for exactly one clock. It sits between the keypad pins and the keypad decoder/parameter-entry FSM, which consumes `keypad_row`/`keypad_col` and treats every cycle's code as a new keystroke.

---
 rtl/keypad_scan4x4_if.sv | 19 +
 rtl/keypad_scan4x4.sv | 139 +++++++++++++
 tb/tb_keypad_scan4x4.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan4x4_if.sv
// Keypad pin bundle plus decoded key outputs; master = scanner, slave = keypad/decoder side.
interface keypad_scan4x4_if;
    logic [3:0] row_drive;
    logic [3:0] col_sense;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_drive, keypad_row, keypad_col, key_valid, key_held,
        input  col_sense
    );

    modport slave (
        input  row_drive, keypad_row, keypad_col, key_valid, key_held,
        output col_sense
    );
endinterface

// File: rtl/keypad_scan4x4.sv
// 4x4 keypad row scanner with per-frame debounce and ghost rejection; one-clock key code per press.
// Report lands one clock after the frame that completes debounce; no backpressure, consumer must take every pulse.
module keypad_scan4x4 #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scan4x4_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_CNT);

    localparam logic [1:0] CAND_NONE  = 2'd0;
    localparam logic [1:0] CAND_KEY   = 2'd1;
    localparam logic [1:0] CAND_GHOST = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REPORT = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic [3:0]    col_s1, col_s2;
    logic [1:0]    idx;
    logic [SW-1:0] slot;
    logic [11:0]   frame_acc;
    logic [1:0]    state;
    logic [CW-1:0] stable;
    logic [1:0]    prev_type;
    logic [7:0]    prev_code;

    logic          slot_end, frame_end;
    logic [15:0]   frame;
    logic [4:0]    n_low;
    logic [3:0]    row_pat, col_pat;
    logic [1:0]    cand_type;
    logic          cand_same;
    logic [CW-1:0] stable_nxt;
    logic          stable_done;

    assign slot_end  = (slot == SLOT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    // Row 3 is taken straight from the synchroniser so evaluation happens on its sample cycle.
    assign frame     = {col_s2, frame_acc};

    always_comb begin
        n_low   = 5'd0;
        row_pat = 4'hF;
        col_pat = 4'hF;
        for (int i = 0; i < 16; i++) begin
            n_low = n_low + {4'b0000, ~frame[i]};
        end
        for (int r = 0; r < 4; r++) begin
            if (frame[r*4 +: 4] != 4'hF) begin
                row_pat = ~(4'b0001 << r);
                col_pat = frame[r*4 +: 4];
            end
        end
        if (n_low == 5'd0)      cand_type = CAND_NONE;
        else if (n_low == 5'd1) cand_type = CAND_KEY;
        else                    cand_type = CAND_GHOST;
        // A ghost frame never counts as a repeat, so ghosting can never debounce into anything.
        cand_same   = (cand_type != CAND_GHOST) && (cand_type == prev_type) &&
                      ({row_pat, col_pat} == prev_code);
        if (!cand_same)                stable_nxt = CW'(1);
        else if (stable == STABLE_MAX) stable_nxt = stable;
        else                           stable_nxt = stable + CW'(1);
        stable_done = (stable_nxt == STABLE_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_s1       <= 4'hF;
            col_s2       <= 4'hF;
            idx          <= 2'd0;
            slot         <= '0;
            frame_acc    <= 12'hFFF;
            kp.row_drive <= 4'b1110;
        end else begin
            col_s1 <= kp.col_sense;
            col_s2 <= col_s1;
            if (slot_end) begin
                slot         <= '0;
                idx          <= idx + 2'd1;
                kp.row_drive <= ~(4'b0001 << (idx + 2'd1));
                case (idx)
                    2'd0:    frame_acc[3:0]  <= col_s2;
                    2'd1:    frame_acc[7:4]  <= col_s2;
                    2'd2:    frame_acc[11:8] <= col_s2;
                    default: ;
                endcase
            end else begin
                slot <= slot + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            stable        <= '0;
            prev_type     <= CAND_NONE;
            prev_code     <= 8'hFF;
            kp.keypad_row <= 4'hF;
            kp.keypad_col <= 4'hF;
            kp.key_valid  <= 1'b0;
            kp.key_held   <= 1'b0;
        end else begin
            kp.keypad_row <= 4'hF;
            kp.keypad_col <= 4'hF;
            kp.key_valid  <= 1'b0;
            if (frame_end) begin
                stable    <= stable_nxt;
                prev_type <= cand_type;
                prev_code <= {row_pat, col_pat};
            end
            case (state)
                ST_IDLE: begin
                    if (frame_end && cand_type == CAND_KEY && stable_done) begin
                        state         <= ST_REPORT;
                        kp.keypad_row <= row_pat;
                        kp.keypad_col <= col_pat;
                        kp.key_valid  <= 1'b1;
                        kp.key_held   <= 1'b1;
                    end
                end
                ST_REPORT: state <= ST_HELD;
                ST_HELD: begin
                    if (frame_end && cand_type == CAND_NONE && stable_done) begin
                        state       <= ST_IDLE;
                        kp.key_held <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with an ideal keypad model (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scan4x4;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;
    localparam int LAT_MIN = (DB - 1) * FR + 3;
    localparam int LAT_MAX = DB * FR + FR + 3;

    localparam logic [15:0] K1 = 16'h0001;  // r0 c0
    localparam logic [15:0] K2 = 16'h0002;  // r0 c1
    localparam logic [15:0] KA = 16'h0008;  // r0 c3
    localparam logic [15:0] K5 = 16'h0020;  // r1 c1
    localparam logic [15:0] K7 = 16'h0100;  // r2 c0
    localparam logic [15:0] K9 = 16'h0400;  // r2 c2
    localparam logic [15:0] K0 = 16'h2000;  // r3 c1
    localparam logic [15:0] KF = 16'h4000;  // r3 c2

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          pulses;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        held;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] keys;
    logic [3:0]  cs;
    int checks = 0, errors = 0, cyc = 0;
    int pulse_cnt = 0, last_pulse_cyc = 0;
    logic [3:0] last_row = 4'hF, last_col = 4'hF;
    logic prev_valid = 1'b0;
    vec_t vecs [23];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    keypad_scan4x4_if bus ();

    keypad_scan4x4 #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (bus)
    );

    always_comb begin
        cs = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.row_drive[r]) cs[c] = 1'b0;
    end
    assign bus.col_sense = cs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] k, input int f, input int p,
                                input logic [3:0] r, input logic [3:0] c, input logic h);
        vec_t v;
        v.keys = k; v.frames = f; v.pulses = p; v.row = r; v.col = c; v.held = h;
        return v;
    endfunction

    always @(negedge clk) begin
        if (bus.key_valid) begin
            check("consec_valid", 32'(prev_valid), 32'd0);
            check("held_on_report", 32'(bus.key_held), 32'd1);
            pulse_cnt      = pulse_cnt + 1;
            last_row       = bus.keypad_row;
            last_col       = bus.keypad_col;
            last_pulse_cyc = cyc;
        end else begin
            check("idle_code", 32'({bus.keypad_row, bus.keypad_col}), 32'hFF);
        end
        prev_valid = bus.key_valid;
    end

    task automatic run_step(input int i);
        int start_cnt, start_cyc;
        keys      = vecs[i].keys;
        start_cnt = pulse_cnt;
        start_cyc = cyc;
        repeat (vecs[i].frames * FR) @(negedge clk);
        #1;
        check($sformatf("step%0d_pulses", i), 32'(pulse_cnt - start_cnt), 32'(vecs[i].pulses));
        if (vecs[i].pulses == 1) begin
            check($sformatf("step%0d_row", i), 32'(last_row), 32'(vecs[i].row));
            check($sformatf("step%0d_col", i), 32'(last_col), 32'(vecs[i].col));
            check_range($sformatf("step%0d_latency", i), last_pulse_cyc - start_cyc, LAT_MIN, LAT_MAX);
        end
        check($sformatf("step%0d_held", i), 32'(bus.key_held), 32'(vecs[i].held));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_drive"}, 32'(bus.row_drive), 32'hE);
        check({tag, "_code"}, 32'({bus.keypad_row, bus.keypad_col}), 32'hFF);
        check({tag, "_valid"}, 32'(bus.key_valid), 32'd0);
        check({tag, "_held"}, 32'(bus.key_held), 32'd0);
    endtask

    initial begin
        int start_cnt, t0;
        keys  = 16'h0;
        reset = 1'b1;
        vecs[0]  = mk(K5,      10, 1, 4'b1101, 4'b1101, 1'b1);
        vecs[1]  = mk(16'h0,    2, 0, 4'hF,    4'hF,    1'b1);
        vecs[2]  = mk(16'h0,    3, 0, 4'hF,    4'hF,    1'b0);
        vecs[3]  = mk(KA,       1, 0, 4'hF,    4'hF,    1'b0);
        vecs[4]  = mk(16'h0,    1, 0, 4'hF,    4'hF,    1'b0);
        vecs[5]  = mk(KA,       1, 0, 4'hF,    4'hF,    1'b0);
        vecs[6]  = mk(16'h0,    1, 0, 4'hF,    4'hF,    1'b0);
        vecs[7]  = mk(KA,       1, 0, 4'hF,    4'hF,    1'b0);
        vecs[8]  = mk(16'h0,    1, 0, 4'hF,    4'hF,    1'b0);
        vecs[9]  = mk(KA,      10, 1, 4'b1110, 4'b0111, 1'b1);
        vecs[10] = mk(16'h0,    6, 0, 4'hF,    4'hF,    1'b0);
        vecs[11] = mk(K1 | K9,  5, 0, 4'hF,    4'hF,    1'b0);
        vecs[12] = mk(K1,       8, 1, 4'b1110, 4'b1110, 1'b1);
        vecs[13] = mk(16'h0,    6, 0, 4'hF,    4'hF,    1'b0);
        vecs[14] = mk(K0,       2, 0, 4'hF,    4'hF,    1'b0);
        vecs[15] = mk(16'h0,    4, 0, 4'hF,    4'hF,    1'b0);
        vecs[16] = mk(K2,       6, 1, 4'b1110, 4'b1101, 1'b1);
        vecs[17] = mk(K2 | KF,  6, 0, 4'hF,    4'hF,    1'b1);
        vecs[18] = mk(KF,       6, 0, 4'hF,    4'hF,    1'b1);
        vecs[19] = mk(16'h0,    6, 0, 4'hF,    4'hF,    1'b0);
        vecs[20] = mk(KF,       6, 1, 4'b0111, 4'b1011, 1'b1);
        vecs[21] = mk(16'h0,    6, 0, 4'hF,    4'hF,    1'b0);
        vecs[22] = mk(K7,       6, 1, 4'b1011, 4'b1110, 1'b1);

        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (23) @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs("midscan");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        repeat (2) @(negedge clk);
        check("rd_row0", 32'(bus.row_drive), 32'hE);
        repeat (4) @(negedge clk);
        check("rd_row1", 32'(bus.row_drive), 32'hD);
        repeat (4) @(negedge clk);
        check("rd_row2", 32'(bus.row_drive), 32'hB);
        repeat (4) @(negedge clk);
        check("rd_row3", 32'(bus.row_drive), 32'h7);
        repeat (4) @(negedge clk);
        check("rd_wrap", 32'(bus.row_drive), 32'hE);
        repeat (4 * FR) @(negedge clk);
        #1 check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

        for (int i = 0; i < 23; i++) run_step(i);

        // Reset with key 7 still down: history is discarded and the press re-debounces from scratch.
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs("held_reset");
        repeat (3) @(negedge clk);
        start_cnt = pulse_cnt;
        reset     = 1'b1;
        t0        = cyc;
        for (int i = 0; i < 100 && pulse_cnt == start_cnt; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_repulse", 32'(pulse_cnt - start_cnt), 32'd1);
        check("rst_latency", 32'(last_pulse_cyc - t0), 32'(DB * FR));
        check("rst_row", 32'(last_row), 32'hB);
        check("rst_col", 32'(last_col), 32'hE);

        keys = 16'h0;
        repeat (6 * FR) @(negedge clk);
        #1 check("final_released", 32'(bus.key_held), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
